// File: rtl/alu_sequencer.sv
// Command front-end for the 8-bit multi-cycle ALU: it drives the BEGIN/op_code/inbus
// load sequence, waits for an END edge or a timeout, then holds the result for the consumer.
module alu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [7:0] cmd_c,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_hi,
  output logic [7:0] rsp_lo,
  output logic       rsp_timeout,
  output logic       alu_begin,
  output logic [1:0] alu_op_code,
  output logic [7:0] alu_inbus,
  input  logic [7:0] alu_outbus,
  input  logic       alu_end,
  output logic       alu_abort
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BEGIN, S_LOAD0, S_LOAD1, S_LOAD2, S_WAIT, S_ABORT, S_RESP
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } cmd_t;

  state_t     state, state_nx;
  cmd_t       cmd_q;
  logic       end_q;
  logic       end_rise;
  logic [7:0] h1, h2;
  logic [7:0] tmo_cnt;

  assign end_rise = alu_end & ~end_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_valid && cmd_ready) state_nx = S_BEGIN;
      S_BEGIN: state_nx = S_LOAD0;
      S_LOAD0: state_nx = S_LOAD1;
      S_LOAD1: state_nx = (cmd_q.op == 2'b11) ? S_LOAD2 : S_WAIT;
      S_LOAD2: state_nx = S_WAIT;
      // a genuine END edge beats a timeout landing in the same cycle
      S_WAIT: begin
        if (end_rise)                 state_nx = S_RESP;
        else if (tmo_cnt == TMO_LAST) state_nx = S_ABORT;
      end
      S_ABORT: state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ALU-facing outputs decode only from flops, so no input reaches an output combinationally
  always_comb begin
    alu_inbus = '0;
    case (state)
      S_LOAD0: alu_inbus = cmd_q.a;
      S_LOAD1: alu_inbus = cmd_q.b;
      S_LOAD2: alu_inbus = cmd_q.c;
      default: alu_inbus = '0;
    endcase
  end

  assign alu_begin   = (state == S_BEGIN);
  assign alu_abort   = (state == S_ABORT);
  assign rsp_valid   = (state == S_RESP);
  assign alu_op_code = (state == S_IDLE) ? 2'b00 : cmd_q.op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      end_q       <= 1'b0;
      h1          <= '0;
      h2          <= '0;
      tmo_cnt     <= '0;
      cmd_ready   <= 1'b0;
      rsp_hi      <= '0;
      rsp_lo      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      end_q     <= alu_end;
      h1        <= alu_outbus;
      h2        <= h1;
      cmd_ready <= (state_nx == S_IDLE);
      tmo_cnt   <= (state == S_WAIT) ? tmo_cnt + 8'd1 : 8'd0;
      if (state == S_IDLE && cmd_valid && cmd_ready)
        cmd_q <= '{op: cmd_op, a: cmd_a, b: cmd_b, c: cmd_c};
      // the ALU leaves hi then lo on outbus in the two cycles before END rises
      if (state == S_WAIT && end_rise) begin
        rsp_hi      <= cmd_q.op[1] ? h2 : 8'h00;
        rsp_lo      <= h1;
        rsp_timeout <= 1'b0;
      end else if (state == S_WAIT && state_nx == S_ABORT) begin
        rsp_hi      <= '0;
        rsp_lo      <= '0;
        rsp_timeout <= 1'b1;
      end
      if (state == S_RESP && rsp_ready) rsp_timeout <= 1'b0;
    end
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command front-end placed directly upstream of the 8-bit multi-cycle ALU (add/sub, Radix-4 multiply, SRT-2 divide).
- Accepts one complete operation over a valid/ready command port.
- Generates the ALU's BEGIN/op_code/inbus load sequence, then watches for END.
- Captures the result bytes from the ALU outbus and returns them over a valid/ready response port, with a timeout and abort if END never arrives.

Parameters:
- TIMEOUT_CYCLES, 64, number of WAIT cycles without an END rising edge before the operation is aborted (range 4..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- cmd_a  input  8  operand word 0 (add/sub/mul: first operand; div: dividend high byte).
- cmd_b  input  8  operand word 1 (add/sub/mul: second operand; div: dividend low byte).
- cmd_c  input  8  operand word 2 (div only: divisor; ignored otherwise).
- rsp_valid  output  1  result held.
- rsp_ready  input  1  consumer takes the result.
- rsp_hi  output  8  result high byte (mul: product high; div: remainder; add/sub: 8'h00).
- rsp_lo  output  8  result low byte (mul: product low; div: quotient; add/sub: sum/difference).
- rsp_timeout  output  1  result was aborted by timeout; rsp_hi/rsp_lo are 0.
- alu_begin  output  1  to ALU BEGIN.
- alu_op_code  output  2  to ALU op_code.
- alu_inbus  output  8  to ALU inbus.
- alu_outbus  input  8  from ALU outbus.
- alu_end  input  1  from ALU END.
- alu_abort  output  1  one-cycle pulse, ORed externally into the ALU reset.

Behaviour:
- Reset values: cmd_ready=0 in the reset cycle, then 1; all other outputs 0. State=IDLE. Command, history and timeout registers cleared.
- Reset has priority over every other event, including mid-operation; the ALU is reset by the same system reset.
- States: IDLE, BEGIN, LOAD0, LOAD1, LOAD2, WAIT, ABORT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_op/a/b/c and go to BEGIN.
  - cmd_ready is 0 in every other state.
- BEGIN (1 cycle): alu_begin=1; alu_op_code=latched op; alu_inbus=0.
- alu_op_code holds the latched op from BEGIN through RESP; it is 0 in IDLE.
- LOAD0, LOAD1, LOAD2 (1 cycle each): alu_inbus = a, b, c respectively.
  - After LOAD1, go to WAIT if op!=11, else to LOAD2.
- WAIT:
  - alu_inbus=0.
  - The timeout counter is cleared on entry and increments each cycle.
- END detection:
  - end_q registers alu_end every cycle.
  - An END rising edge (alu_end & ~end_q) counts only in WAIT; edges in BEGIN/LOAD states are ignored.
- Output history:
  - h1 = alu_outbus from 1 cycle earlier; h2 = from 2 cycles earlier.
  - h1/h2 shift every cycle.
- On an END rising edge in WAIT, latch the result and go to RESP:
  - mul/div: rsp_hi=h2, rsp_lo=h1.
  - add/sub: rsp_hi=0, rsp_lo=h1.
  - rsp_timeout=0.
- Timeout:
  - If the counter reaches TIMEOUT_CYCLES-1 with no edge, go to ABORT.
  - END and timeout in the same cycle: END wins.
- ABORT (1 cycle): alu_abort=1; rsp_hi=rsp_lo=0; rsp_timeout=1; then go to RESP.
- RESP:
  - rsp_valid=1; rsp_hi/lo/timeout stay stable while rsp_valid&~rsp_ready.
  - On rsp_ready, go to IDLE and drop rsp_valid the next cycle.
  - rsp_timeout clears when leaving RESP.
- Latency: command accept to first WAIT cycle is 4 cycles (add/sub/mul) or 5 cycles (div); response appears 1 cycle after the END edge.
- No command queuing: one operation in flight. cmd_* changes while cmd_ready=0 are ignored.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Add: cmd_op=00, a=8'h05, b=8'h03 against the ALU → alu_begin for exactly 1 cycle; inbus shows 05 then 03; rsp_hi=00, rsp_lo=08, rsp_timeout=0.
- Mul: cmd_op=10, a=8'h0C, b=8'h0A → rsp_hi=00, rsp_lo=78. Signed case a=8'hFD, b=8'h05 → rsp_hi=FF, rsp_lo=F1.
- Div: cmd_op=11, a=8'h00, b=8'h64, c=8'h07 → inbus shows 00, 64, 07 in LOAD0..2; rsp_hi=02 (remainder), rsp_lo=0E (quotient).
- Timeout: ALU stub holds alu_end=0, TIMEOUT_CYCLES=8 → alu_abort pulses 1 cycle after 8 WAIT cycles; rsp_valid with rsp_timeout=1, rsp_hi=rsp_lo=00. A following add command completes normally.
- Backpressure and spurious END:
  - rsp_ready=0 for 10 cycles → rsp_* stable and cmd_ready=0 throughout; accepted 1 cycle after rsp_ready=1.
  - alu_end stuck high from before BEGIN → no capture until a fresh rising edge occurs in WAIT.
- Reset mid-operation: assert reset during LOAD1 of a div → next cycle all outputs 0 and state IDLE; cmd_ready=1 after reset deasserts; a new mul completes with correct result.
